mips_bus_monitor: RTL
=====================

// Module: mips_bus_monitor
// PURPOSE
// - Synthesisable run monitor and Avalon-MM protocol checker for NUM_CH master->slave buses.
// - Sits beside the mips_cpu_bus / memory interconnect and replaces bench-side run control:
//   - run-cycle counting
//   - timeout detection
//   - end-of-run detection (CPU inactive and write buffer empty)
// - Per channel it counts accepted transfers and latches sticky protocol violations.
// PARAMETERS
// NUM_CH          1      number of monitored Avalon-MM channels
// ADDR_W          32     address width per channel
// DATA_W          32     data width per channel; multiple of 8; byteenable width BE_W=DATA_W/8
// TIMEOUT_CYCLES  10000  run-cycle limit before TIMEOUT
// CNT_W           32     width of every counter
// PORTS
// clk          in   1               clock; all logic on rising edge
// reset        in   1               asynchronous, active-low reset
// cpu_active   in   1               CPU active flag
// wb_empty     in   1               CPU write buffer empty
// address      in   NUM_CH*ADDR_W   per-channel address, channel c at [c*ADDR_W +: ADDR_W]
// byteenable   in   NUM_CH*BE_W     per-channel byteenable
// read         in   NUM_CH          per-channel read request
// write        in   NUM_CH          per-channel write request
// writedata    in   NUM_CH*DATA_W   per-channel write data
// waitrequest  in   NUM_CH          per-channel slave stall
// state        out  3               FSM state: IDLE=0, RUN=1, DRAIN=2, DONE=3, TIMEOUT=4
// cycles       out  CNT_W           cycles spent in RUN+DRAIN
// done         out  1               high while state==DONE
// timeout      out  1               high while state==TIMEOUT
// xfer_count   out  NUM_CH*CNT_W    accepted transfers per channel
// violation    out  NUM_CH          sticky protocol-error flag per channel
// viol_code    out  NUM_CH*2        first error code per channel
// BEHAVIOUR
// Reset (reset low, async)
// - All outputs and counters go to 0 and state goes to IDLE immediately, including mid-run.
// FSM (registered; done/timeout decoded from the state register)
// - IDLE -> RUN when cpu_active=1.
// - RUN -> DONE when cpu_active=0 and wb_empty=1.
// - RUN -> DRAIN when cpu_active=0 and wb_empty=0.
// - DRAIN -> DONE when wb_empty=1 and cpu_active=0.
// - DRAIN -> RUN when cpu_active=1 (takes priority over DONE).
// - DONE and TIMEOUT are terminal until reset.
// Cycle counter and timeout
// - cycles increments once per clock in RUN or DRAIN.
// - When cycles==TIMEOUT_CYCLES at a RUN/DRAIN edge:
//   - if no finish transition is due, go to TIMEOUT;
//   - a finish transition on the same edge wins over TIMEOUT.
// - cycles freezes outside RUN/DRAIN.
// Transfer counter, channel c
// - Accepted transfer = (read|write)&~waitrequest.
// - xfer_count increments by 1 per accepted transfer in any state and saturates at all-ones.
// Protocol checks, channel c; evaluated every cycle in every state
// - 01: read and write both high.
// - 10: previous cycle had a request with waitrequest=1, and this cycle any of
//   address, byteenable, read, write, or (for a write) writedata differs from the previous cycle.
// - 11: request high with byteenable==0.
// - Any check sets violation[c] on the next edge; viol_code[c] captures the code.
// - Later errors never overwrite viol_code; only reset clears it.
// - Priority within a cycle: 01 > 10 > 11.
// - Monitor is passive: no output feeds back into the bus.
// CONFIGURATION
// MIPS_BUS_MON_STALL_EN
// - Defined:
//   - adds output stall_count [NUM_CH*CNT_W], reset to 0;
//   - counts cycles with (read|write)&waitrequest per channel;
//   - saturating; counts in all states.
// - Undefined: port and logic absent; all other behaviour identical.
// TESTING
// 1. cpu_active=1 for 20 cycles, then 0 with wb_empty=1
//    -> RUN, then DONE on the next edge; cycles=20; done=1 held.
// 2. cpu_active=0 with wb_empty=0 for 4 cycles, then wb_empty=1
//    -> DRAIN, then DONE; cycles=24.
//    Repeat with cpu_active pulsed high during DRAIN -> back to RUN.
// 3. TIMEOUT_CYCLES=50, cpu_active held 1
//    -> timeout=1 and state=4 after the 50th counted cycle; cycles frozen at 50.
// 4. Ch0 read at 0x100 with waitrequest=1 for 3 cycles; address changes to 0x104 in cycle 2
//    -> violation[0]=1, viol_code[0]=2'b10; xfer_count[0]=1 after waitrequest drops.
// 5. Ch0 read&write in the same cycle, then a read with byteenable=0
//    -> viol_code[0]=2'b01 and it stays 01.
// 6. NUM_CH=2: ch0 2 reads, ch1 5 writes (1 wait each); reset pulsed low mid-RUN afterwards
//    -> before reset: xfer_count ch0=2, ch1=5; stall_count 2/5 with MIPS_BUS_MON_STALL_EN;
//    -> on reset: all outputs 0 immediately.

Source files
------------

// File: rtl/mips_bus_monitor.sv
// Run monitor and Avalon-MM protocol checker for NUM_CH master->slave buses.
// Optional stall counters are enabled with `define MIPS_BUS_MON_STALL_EN.
module mips_bus_monitor #(
   parameter int NUM_CH         = 1,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 10000,
   parameter int CNT_W          = 32,
   localparam int BE_W          = DATA_W / 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cpu_active,
   input  logic                     wb_empty,
   input  logic [NUM_CH*ADDR_W-1:0] address,
   input  logic [NUM_CH*BE_W-1:0]   byteenable,
   input  logic [NUM_CH-1:0]        read,
   input  logic [NUM_CH-1:0]        write,
   input  logic [NUM_CH*DATA_W-1:0] writedata,
   input  logic [NUM_CH-1:0]        waitrequest,
   output logic [2:0]               state,
   output logic [CNT_W-1:0]         cycles,
   output logic                     done,
   output logic                     timeout,
   output logic [NUM_CH*CNT_W-1:0]  xfer_count,
   output logic [NUM_CH-1:0]        violation,
   output logic [NUM_CH*2-1:0]      viol_code
`ifdef MIPS_BUS_MON_STALL_EN
   ,
   output logic [NUM_CH*CNT_W-1:0]  stall_count
`endif
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RUN     = 3'd1,
      S_DRAIN   = 3'd2,
      S_DONE    = 3'd3,
      S_TIMEOUT = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cycles_q, cycles_d;
   logic             finish;
   logic             at_limit;

   always_comb begin
      state_d  = state_q;
      cycles_d = cycles_q;
      finish   = !cpu_active && wb_empty;
      at_limit = (cycles_q == CNT_W'(TIMEOUT_CYCLES));
      unique case (state_q)
         S_IDLE: begin
            if (cpu_active) state_d = S_RUN;
         end
         S_RUN, S_DRAIN: begin
            // the counter parks at the limit so it reads exactly TIMEOUT_CYCLES
            if (!at_limit) cycles_d = cycles_q + 1'b1;
            if (finish)                                state_d = S_DONE;
            else if (at_limit)                         state_d = S_TIMEOUT;
            else if (state_q == S_DRAIN && cpu_active) state_d = S_RUN;
            else if (state_q == S_RUN && !cpu_active)  state_d = S_DRAIN;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cycles_q <= '0;
      end else begin
         state_q  <= state_d;
         cycles_q <= cycles_d;
      end
   end

   assign state   = state_q;
   assign cycles  = cycles_q;
   assign done    = (state_q == S_DONE);
   assign timeout = (state_q == S_TIMEOUT);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [ADDR_W-1:0] addr;
      logic [BE_W-1:0]   be;
      logic [DATA_W-1:0] wd;
      logic              rd, wr, wt, req, changed;
      logic [ADDR_W-1:0] p_addr_q;
      logic [BE_W-1:0]   p_be_q;
      logic [DATA_W-1:0] p_wd_q;
      logic              p_rd_q, p_wr_q, p_pend_q;
      logic [CNT_W-1:0]  xfer_q, xfer_d;
      logic              viol_q, viol_d;
      logic [1:0]        code_q, code_d, err;

      assign addr = address[c*ADDR_W +: ADDR_W];
      assign be   = byteenable[c*BE_W +: BE_W];
      assign wd   = writedata[c*DATA_W +: DATA_W];
      assign rd   = read[c];
      assign wr   = write[c];
      assign wt   = waitrequest[c];

      always_comb begin
         req     = rd | wr;
         changed = (addr != p_addr_q) || (be != p_be_q) ||
                   (rd != p_rd_q) || (wr != p_wr_q) ||
                   (wr && (wd != p_wd_q));
         err     = 2'b00;
         if (rd && wr)                err = 2'b01;
         else if (p_pend_q && changed) err = 2'b10;
         else if (req && be == '0)     err = 2'b11;
         xfer_d = xfer_q;
         if (req && !wt && xfer_q != '1) xfer_d = xfer_q + 1'b1;
         viol_d = viol_q;
         code_d = code_q;
         if (!viol_q && err != 2'b00) begin
            viol_d = 1'b1;
            code_d = err;
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            p_addr_q <= '0;
            p_be_q   <= '0;
            p_wd_q   <= '0;
            p_rd_q   <= 1'b0;
            p_wr_q   <= 1'b0;
            p_pend_q <= 1'b0;
            xfer_q   <= '0;
            viol_q   <= 1'b0;
            code_q   <= 2'b00;
         end else begin
            p_addr_q <= addr;
            p_be_q   <= be;
            p_wd_q   <= wd;
            p_rd_q   <= rd;
            p_wr_q   <= wr;
            p_pend_q <= req & wt;
            xfer_q   <= xfer_d;
            viol_q   <= viol_d;
            code_q   <= code_d;
         end
      end

      assign xfer_count[c*CNT_W +: CNT_W] = xfer_q;
      assign violation[c]                 = viol_q;
      assign viol_code[c*2 +: 2]          = code_q;

`ifdef MIPS_BUS_MON_STALL_EN
      logic [CNT_W-1:0] stall_q, stall_d;

      always_comb begin
         stall_d = stall_q;
         if (req && wt && stall_q != '1) stall_d = stall_q + 1'b1;
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) stall_q <= '0;
         else        stall_q <= stall_d;
      end

      assign stall_count[c*CNT_W +: CNT_W] = stall_q;
`endif
   end

endmodule
